// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRON,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_WAIT
  } state_e;

  localparam int         INIT_LEN  = 4;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Power-on command list: 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return CMD_CLEAR;
      default: return 8'h06;
    endcase
  endfunction

  // Clear and home (0x03 decodes as home too) need the 2 ms execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Write buffer for {rs, data} bytes; registered ready so software sees a clean flag.
module lcd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [8:0] wdata_i,
  output logic [8:0] rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       empty_nxt_o,
  output logic       ready_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q;
  logic          do_push, do_pop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign count_d     = count_q + CW'(do_push) - CW'(do_pop);
  assign empty_nxt_o = (count_d == '0);
  assign rdata_o     = mem_q[rd_ptr_q];
  assign ready_o     = ready_q;

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: autonomous init, buffered writes, bus timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = 4,
  parameter int EN_HIGH_CYC  = 25,
  parameter int HOLD_CYC     = 4,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int PWRON_CYC    = 2000000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_valid_i,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);
  localparam int MAXC = (PWRON_CYC > CLR_WAIT_CYC) ? PWRON_CYC : CLR_WAIT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LD_PWRON = CW'(PWRON_CYC - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(CLR_WAIT_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, on_q, busy_q;

  logic       push, pop;
  logic [8:0] head;
  logic       fifo_full, fifo_empty, fifo_empty_nxt;

  assign push = wr_valid_i && wr_ready_o && !fifo_full;
  assign pop  = (state_q == ST_IDLE) && done_q && !fifo_empty;

  lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    ({wr_rs_i, wr_data_i}),
    .rdata_o    (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .empty_nxt_o(fifo_empty_nxt),
    .ready_o    (wr_ready_o)
  );

  // Sequencer: one shared down-counter, reloaded with N-1 on each state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    idx_d   = idx_q;
    done_d  = done_q;
    data_d  = data_q;
    rs_d    = rs_q;
    case (state_q)
      ST_PWRON: if (cnt_q == '0) state_d = ST_INIT;
      ST_INIT: begin
        data_d  = init_rom(idx_q[1:0]);
        rs_d    = 1'b0;
        idx_d   = idx_q + 3'd1;
        state_d = ST_SETUP;
        cnt_d   = LD_SETUP;
      end
      ST_IDLE: if (pop) begin
        {rs_d, data_d} = head;
        state_d        = ST_SETUP;
        cnt_d          = LD_SETUP;
      end
      ST_SETUP: if (cnt_q == '0) begin
        state_d = ST_EN_HI;
        cnt_d   = LD_EN;
      end
      ST_EN_HI: if (cnt_q == '0) begin
        state_d = ST_HOLD;
        cnt_d   = LD_HOLD;
      end
      ST_HOLD: if (cnt_q == '0) begin
        state_d = ST_WAIT;
        cnt_d   = is_long_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
      end
      ST_WAIT: if (cnt_q == '0) begin
        if (!done_q && idx_q != 3'(INIT_LEN)) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_PWRON;
    endcase
  end

  // State and pin registers; EN is decoded from the next state so it never glitches.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_PWRON;
      cnt_q   <= LD_PWRON;
      idx_q   <= '0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= (state_d == ST_EN_HI);
      on_q    <= 1'b1;
      busy_q  <= !fifo_empty_nxt || (state_d != ST_IDLE);
    end
  end

  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = en_q;
  assign lcd_on_o    = on_q;
  assign busy_o      = busy_q;
  assign init_done_o = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened power-on and execution waits.
module tb_lcd_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       wr_valid_i = 1'b0;
  logic       wr_rs_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       wr_ready_o, busy_o, init_done_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o;

  lcd_ctrl #(
    .PWRON_CYC(20), .CMD_WAIT_CYC(10), .CLR_WAIT_CYC(40)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_valid_i(wr_valid_i), .wr_rs_i(wr_rs_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .busy_o(busy_o), .init_done_o(init_done_o),
    .lcd_data_o(lcd_data_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
    .lcd_en_o(lcd_en_o), .lcd_on_o(lcd_on_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Bus monitor: logs every EN pulse with its byte, rise/fall cycle and setup margin.
  logic [8:0] mon_bus;
  assign mon_bus = {lcd_rs_o, lcd_data_o};
  logic [8:0] bus_prev = 9'h1FF;
  logic       en_prev = 1'b0;
  logic       have_fall = 1'b0;
  int         last_chg = 0, rise_last = 0, fall_cyc = 0, hold_viol = 0;
  logic [8:0] p_bus[$];
  int         p_rise[$], p_fall[$], p_width[$], p_setup[$];

  always @(negedge clk_i) begin
    if (mon_bus !== bus_prev) begin
      if (have_fall && (cyc - fall_cyc) < 4) hold_viol <= hold_viol + 1;
      last_chg <= cyc;
      bus_prev <= mon_bus;
    end
    if (lcd_en_o === 1'b1 && en_prev === 1'b0) begin
      p_bus.push_back(mon_bus);
      p_rise.push_back(cyc);
      p_setup.push_back((mon_bus !== bus_prev) ? 0 : cyc - last_chg);
      rise_last <= cyc;
    end
    if (lcd_en_o === 1'b0 && en_prev === 1'b1) begin
      p_width.push_back(cyc - rise_last);
      p_fall.push_back(cyc);
      fall_cyc  <= cyc;
      have_fall <= 1'b1;
    end
    en_prev <= lcd_en_o;
  end

  int n_total = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offer one byte starting at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    int t = 0;
    wr_valid_i = 1'b1; wr_rs_i = rs; wr_data_i = d;
    while (wr_ready_o !== 1'b1 && t < 500) begin @(negedge clk_i); t++; end
    chk("send_accept", 32'(t < 500), 32'd1);
    @(negedge clk_i);
    acc = cyc;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while ((init_done_o !== 1'b1 || busy_o !== 1'b0) && t < bound) begin
      @(negedge clk_i); t++;
    end
    chk("idle_wait", 32'(t < bound), 32'd1);
  endtask

  task automatic chk_pulse(input string tag, input int i, input logic [8:0] exp_bus);
    chk({tag, "_present"}, 32'(p_bus.size() > i), 32'd1);
    if (p_bus.size() > i) begin
      chk({tag, "_bus"}, 32'(p_bus[i]), 32'(exp_bus));
      chk({tag, "_width"}, 32'(p_width[i]), 32'd25);
    end
  endtask

  initial begin
    int acc, a, cr, t;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_data", 32'(lcd_data_o), 32'h00);
    chk("rst_rs", 32'(lcd_rs_o), 32'd0);
    chk("rst_rw", 32'(lcd_rw_o), 32'd0);
    chk("rst_en", 32'(lcd_en_o), 32'd0);
    chk("rst_on", 32'(lcd_on_o), 32'd0);
    chk("rst_ready", 32'(wr_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(init_done_o), 32'd0);

    // Power-on init with no writes
    rst_ni = 1'b1;
    @(negedge clk_i);
    cr = cyc;
    chk("on_after_rst", 32'(lcd_on_o), 32'd1);
    chk("ready_after_rst", 32'(wr_ready_o), 32'd1);
    chk("done_low_in_pwron", 32'(init_done_o), 32'd0);
    wait_idle(2000);
    chk("init_pulses", 32'(p_bus.size()), 32'd4);
    chk_pulse("init0", 0, 9'h038);
    chk_pulse("init1", 1, 9'h00C);
    chk_pulse("init2", 2, 9'h001);
    chk_pulse("init3", 3, 9'h006);
    if (p_rise.size() >= 4) begin
      chk("init_first_rise", 32'(p_rise[0] - cr), 32'd24);
      chk("init_gap_short", 32'(p_rise[1] - p_fall[0]), 32'd19);
      chk("init_gap_clear", 32'(p_rise[3] - p_fall[2]), 32'd49);
    end
    chk("init_done", 32'(init_done_o), 32'd1);
    chk("rw_low", 32'(lcd_rw_o), 32'd0);

    // Single data write 0x41
    send(1'b1, 8'h41, acc);
    wr_valid_i = 1'b0;
    chk("busy_after_push", 32'(busy_o), 32'd1);
    wait_idle(500);
    chk_pulse("w41", 4, 9'h141);
    if (p_rise.size() > 4) begin
      chk("w41_rise_lat", 32'(p_rise[4] - acc), 32'd5);
      chk("w41_setup", 32'(p_setup[4]), 32'd4);
    end
    chk("hold_ok_a", 32'(hold_viol), 32'd0);
    chk("idle_retain_data", 32'(lcd_data_o), 32'h41);
    chk("idle_retain_rs", 32'(lcd_rs_o), 32'd1);

    // Clear then set-address: long wait then short wait
    send(1'b0, 8'h01, acc);
    send(1'b0, 8'h80, acc);
    send(1'b1, 8'h5A, acc);
    wr_valid_i = 1'b0;
    wait_idle(1000);
    chk_pulse("clr", 5, 9'h001);
    chk_pulse("addr", 6, 9'h080);
    chk_pulse("after", 7, 9'h15A);
    if (p_rise.size() > 7) begin
      chk("gap_after_clear", 32'(p_rise[6] - p_fall[5]), 32'd49);
      chk("gap_after_cmd", 32'(p_rise[7] - p_fall[6]), 32'd19);
    end
    chk("hold_ok_b", 32'(hold_viol), 32'd0);

    // Simultaneous push and pop with three entries queued
    send(1'b1, 8'h61, a);
    send(1'b1, 8'h62, acc);
    send(1'b1, 8'h63, acc);
    send(1'b1, 8'h64, acc);
    wr_valid_i = 1'b0;
    t = 0;
    while (cyc < a + 44 && t < 200) begin @(negedge clk_i); t++; end
    chk("reach_pop_edge", 32'(cyc), 32'(a + 44));
    chk("ready_at_3", 32'(wr_ready_o), 32'd1);
    wr_valid_i = 1'b1; wr_rs_i = 1'b1; wr_data_i = 8'h65;
    @(negedge clk_i);
    wr_valid_i = 1'b0;
    chk("pushpop_count", 32'(dut.u_fifo.count_q), 32'd3);
    wait_idle(1000);
    chk_pulse("pp_a", 8, 9'h161);
    chk_pulse("pp_b", 9, 9'h162);
    chk_pulse("pp_c", 10, 9'h163);
    chk_pulse("pp_d", 11, 9'h164);
    chk_pulse("pp_e", 12, 9'h165);
    if (p_rise.size() > 9) chk("pp_b_rise", 32'(p_rise[9] - a), 32'd49);

    // Reset while EN is high, with a second byte still buffered
    send(1'b1, 8'h70, acc);
    send(1'b1, 8'h71, acc);
    wr_valid_i = 1'b0;
    t = 0;
    while (lcd_en_o !== 1'b1 && t < 50) begin @(negedge clk_i); t++; end
    chk("en_seen", 32'(lcd_en_o), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst_en", 32'(lcd_en_o), 32'd0);
    chk("midrst_data", 32'(lcd_data_o), 32'h00);
    chk("midrst_ready", 32'(wr_ready_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(init_done_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    cr = cyc;
    wait_idle(2000);
    chk("replay_pulses", 32'(p_bus.size()), 32'd18);
    chk_pulse("replay0", 14, 9'h038);
    chk_pulse("replay3", 17, 9'h006);
    if (p_rise.size() > 14) chk("replay_rise", 32'(p_rise[14] - cr), 32'd24);

    // Six back-to-back writes during power-on wait
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    send(1'b1, 8'h48, acc);
    send(1'b1, 8'h49, acc);
    send(1'b0, 8'h80, acc);
    send(1'b1, 8'h4A, acc);
    chk("full_after_4", 32'(wr_ready_o), 32'd0);
    chk("done_low_while_full", 32'(init_done_o), 32'd0);
    send(1'b0, 8'hC0, acc);
    send(1'b1, 8'h4B, acc);
    wr_valid_i = 1'b0;
    wait_idle(2000);
    chk("b2b_pulses", 32'(p_bus.size()), 32'd28);
    chk_pulse("b2b_init0", 18, 9'h038);
    chk_pulse("b2b_init3", 21, 9'h006);
    chk_pulse("b2b_0", 22, 9'h148);
    chk_pulse("b2b_1", 23, 9'h149);
    chk_pulse("b2b_2", 24, 9'h080);
    chk_pulse("b2b_3", 25, 9'h14A);
    chk_pulse("b2b_4", 26, 9'h0C0);
    chk_pulse("b2b_5", 27, 9'h14B);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
